// File: rtl/mem_access_stage_if.sv
// Data memory request/acknowledge bus between the memory stage and data memory.
// master: memory stage drives req/we/addr/wdata and receives rdata/ack.
// slave: data memory side, the mirror image of master.
interface mem_access_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage of the 16-bit pipelined CPU: issues loads/stores over a req/ack bus and fills the MEM/WB register.
// Ports: clk/rst, EX/MEM fields (*_in), combinational stall_o, dmem bus (master modport), MEM/WB outputs, sticky err_o.
// Latency: non-memory ops 1 cycle; memory ops complete on the ack edge, or abort after TIMEOUT REQ cycles.
module mem_access_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wbs_in,
    input  logic [1:0]           mm_in,
    input  logic [DATA_W-1:0]    alu_result_in,
    input  logic [DATA_W-1:0]    mem_data_in,
    input  logic                 wm_in,
    input  logic                 ni_in,
    output logic                 stall_o,
    mem_access_stage_if.master   dmem,
    output logic                 wbs_out,
    output logic [DATA_W-1:0]    wb_data_out,
    output logic                 ni_out,
    output logic                 err_o
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wbs_lat;
    logic             access;
    logic             last_wait;

    // A store wins over a load when both are flagged; dmem.we records which.
    assign access    = !ni_in && (wm_in || (mm_in == 2'b01));
    assign last_wait = (cnt == CNT_W'(TIMEOUT - 1));

    // Upstream is released in the ack cycle and in the abort cycle.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = access;
            REQ:     stall_o = !dmem.ack && !last_wait;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dmem.req    <= 1'b0;
            dmem.we     <= 1'b0;
            dmem.addr   <= '0;
            dmem.wdata  <= '0;
            wbs_lat     <= 1'b0;
            cnt         <= '0;
            wbs_out     <= 1'b0;
            wb_data_out <= '0;
            ni_out      <= 1'b1;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        dmem.req   <= 1'b1;
                        dmem.we    <= wm_in;
                        dmem.addr  <= alu_result_in[ADDR_W-1:0];
                        dmem.wdata <= mem_data_in;
                        wbs_lat    <= wbs_in;
                        cnt        <= '0;
                        state      <= REQ;
                        ni_out     <= 1'b1;
                        wbs_out    <= 1'b0;
                    end else begin
                        // An ack arriving here is stale and deliberately ignored.
                        wbs_out     <= wbs_in && !ni_in;
                        ni_out      <= ni_in;
                        wb_data_out <= (mm_in == 2'b10) ? mem_data_in : alu_result_in;
                    end
                end
                REQ: begin
                    if (dmem.ack) begin
                        // Ack beats a timeout landing in the same cycle.
                        dmem.req    <= 1'b0;
                        state       <= IDLE;
                        ni_out      <= 1'b0;
                        wbs_out     <= wbs_lat;
                        wb_data_out <= dmem.we ? DATA_W'(dmem.addr) : dmem.rdata;
                    end else if (last_wait) begin
                        // Abort: drop the instruction and flag the error until reset.
                        dmem.req <= 1'b0;
                        err_o    <= 1'b1;
                        state    <= IDLE;
                        ni_out   <= 1'b1;
                        wbs_out  <= 1'b0;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        ni_out  <= 1'b1;
                        wbs_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_in;
    logic [1:0]  mm_in;
    logic [15:0] alu_result_in;
    logic [15:0] mem_data_in;
    logic        wm_in;
    logic        ni_in;
    logic        stall_o;
    logic        wbs_out;
    logic [15:0] wb_data_out;
    logic        ni_out;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    logic exp_err = 1'b0;

    mem_access_stage_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_access_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .wbs_in        (wbs_in),
        .mm_in         (mm_in),
        .alu_result_in (alu_result_in),
        .mem_data_in   (mem_data_in),
        .wm_in         (wm_in),
        .ni_in         (ni_in),
        .stall_o       (stall_o),
        .dmem          (bus),
        .wbs_out       (wbs_out),
        .wb_data_out   (wb_data_out),
        .ni_out        (ni_out),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction at the EX/MEM boundary. k = REQ cycle (1-based) in which
    // memory acks; k = 0 means memory never answers.
    task automatic do_instr(input logic wbs, input logic [1:0] mm, input logic [15:0] alu,
                            input logic [15:0] md, input logic wm, input logic ni,
                            input int k, input logic [15:0] rd);
        logic acc;
        int   req_cycles;
        acc = !ni && (wm || mm == 2'b01);
        wbs_in = wbs; mm_in = mm; alu_result_in = alu; mem_data_in = md; wm_in = wm; ni_in = ni;
        @(negedge clk);
        chk("issue_stall", stall_o, acc);
        @(posedge clk); #1;
        if (!acc) begin
            chk("alu_wbs", wbs_out, wbs && !ni);
            chk("alu_ni", ni_out, ni);
            chk("alu_noreq", bus.req, 1'b0);
            if (!ni) chk("alu_data", wb_data_out, (mm == 2'b10) ? md : alu);
        end else begin
            req_cycles = 0;
            for (int j = 1; j <= TIMEOUT; j++) begin
                if (j == k) begin
                    bus.ack = 1'b1; bus.rdata = rd;
                end
                @(negedge clk);
                if (bus.req === 1'b1) req_cycles++;
                chk("req_hi", bus.req, 1'b1);
                chk("req_we", bus.we, wm);
                chk("req_addr", bus.addr, alu);
                if (wm) chk("req_wdata", bus.wdata, md);
                chk("req_stall", stall_o, (j != k) && (j != TIMEOUT));
                if (j != k) chk("req_bubble", ni_out, 1'b1);
                @(posedge clk); #1;
                bus.ack = 1'b0;
                if (j == k) break;
            end
            chk("req_dropped", bus.req, 1'b0);
            if (k >= 1 && k <= TIMEOUT) begin
                chk("done_ni", ni_out, 1'b0);
                chk("done_wbs", wbs_out, wbs);
                chk("done_data", wb_data_out, wm ? alu : rd);
            end else begin
                exp_err = 1'b1;
                chk("to_cycles", req_cycles, TIMEOUT);
                chk("to_ni", ni_out, 1'b1);
                chk("to_wbs", wbs_out, 1'b0);
            end
        end
        chk("err", err_o, exp_err);
    endtask

    initial begin
        rst = 1'b1; wbs_in = 0; mm_in = 0; alu_result_in = 0; mem_data_in = 0;
        wm_in = 0; ni_in = 1'b1; bus.ack = 1'b0; bus.rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ni", ni_out, 1'b1);
        chk("rst_wbs", wbs_out, 1'b0);
        chk("rst_data", wb_data_out, 16'h0);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_addr", bus.addr, 16'h0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_err", err_o, 1'b0);

        // Bubble held, then directed ops.
        do_instr(1'b1, 2'b01, 16'h0040, 16'h0, 1'b0, 1'b1, 1, 16'h0);
        do_instr(1'b1, 2'b00, 16'h1234, 16'h5555, 1'b0, 1'b0, 1, 16'h0);
        do_instr(1'b1, 2'b10, 16'h1234, 16'h5555, 1'b0, 1'b0, 1, 16'h0);
        do_instr(1'b1, 2'b01, 16'h0040, 16'h0, 1'b0, 1'b0, 4, 16'hBEEF);
        do_instr(1'b1, 2'b00, 16'h0010, 16'hA5A5, 1'b1, 1'b0, 1, 16'h0);
        do_instr(1'b1, 2'b01, 16'h0077, 16'h0, 1'b1, 1'b0, 2, 16'hDEAD);
        do_instr(1'b1, 2'b01, 16'h0080, 16'h0, 1'b0, 1'b0, TIMEOUT, 16'h1111);
        do_instr(1'b1, 2'b01, 16'h0090, 16'h0, 1'b0, 1'b0, 0, 16'h0);
        do_instr(1'b1, 2'b00, 16'h4321, 16'h0, 1'b0, 1'b0, 1, 16'h0);

        // Stale ack in IDLE must not disturb an ALU op.
        bus.ack = 1'b1; bus.rdata = 16'hFFFF;
        do_instr(1'b0, 2'b11, 16'h0abc, 16'h0, 1'b0, 1'b0, 1, 16'h0);
        bus.ack = 1'b0;

        // Randomized instruction mix against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            int kk;
            kk = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
            do_instr(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                     kk, 16'($urandom));
        end

        // Reset in the 2nd REQ cycle, late ack afterwards.
        wbs_in = 1'b1; mm_in = 2'b01; alu_result_in = 16'h0300; wm_in = 1'b0; ni_in = 1'b0;
        @(posedge clk); #1;
        chk("mid_req1", bus.req, 1'b1);
        @(posedge clk); #1;
        chk("mid_req2", bus.req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_err = 1'b0;
        chk("mid_rst_req", bus.req, 1'b0);
        ni_in = 1'b1; bus.ack = 1'b1; bus.rdata = 16'h5A5A;
        @(negedge clk);
        chk("mid_rst_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        bus.ack = 1'b0;
        chk("late_ack_ni", ni_out, 1'b1);
        chk("late_ack_wbs", wbs_out, 1'b0);
        chk("late_ack_req", bus.req, 1'b0);
        chk("late_ack_err", err_o, 1'b0);
        do_instr(1'b1, 2'b00, 16'h2468, 16'h0, 1'b0, 1'b0, 1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
